lfsr_bit_packer: RTL and testbench
==================================

Name: lfsr_bit_packer

Overview:
- Downstream consumer of the LFSR serial output (OUT/Valid).
- Samples the qualified serial bit stream and packs consecutive bits into WORD_W-bit words.
- Buffers packed words in a small synchronous FIFO.
- Presents words on a valid/ready interface to the word-level logic that follows (checker, scrambler, test-pattern sink).

Parameters:
- WORD_W, 8, bits per packed word (>=2).
- FIFO_DEPTH, 4, word FIFO entries; power of two, >=2.
- MSB_FIRST, 1, 1: first received bit lands in Word_Out[WORD_W-1]; 0: first bit lands in Word_Out[0].

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- Serial_In  in  1  serial bit, driven from LFSR OUT.
- Serial_Valid  in  1  qualifies Serial_In, driven from LFSR Valid.
- Word_Out  out  WORD_W  FIFO head word.
- Word_Valid  out  1  FIFO non-empty.
- Word_Ready  in  1  consumer accepts head this cycle.
- Fill_Level  out  clog2(FIFO_DEPTH)+1  words currently stored.
- Overflow  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async assert, sync-safe deassert by design of upstream): shift register, bit counter, FIFO pointers, Fill_Level, Overflow all 0. Word_Valid=0, Word_Out=0. Any partial word is discarded.
- Bit capture:
  - On each edge with Serial_Valid=1, Serial_In shifts into the accumulator (direction per MSB_FIRST) and the bit counter increments.
  - Serial_Valid=0: accumulator and counter hold; gaps of any length are legal.
- Word completion:
  - On the edge where the counter is WORD_W-1 and Serial_Valid=1, the completed word (including this bit) is pushed to the FIFO and the counter wraps to 0.
  - No bubble: the next bit, if valid on the following edge, starts a new word.
- Latency: Word_Valid rises exactly 1 cycle after the edge that captured the last bit, when the FIFO was empty.
- Output handshake:
  - Word_Valid = (Fill_Level != 0); Word_Out = head entry, or 0 when empty.
  - Pop occurs on an edge with Word_Valid & Word_Ready.
  - Word_Out/Word_Valid must not change while Word_Valid=1 and Word_Ready=0, except when a pop occurs.
  - Word_Ready while empty has no effect.
- Full boundary:
  - Push with FIFO full and no simultaneous pop: word dropped, FIFO unchanged, Overflow set to 1 and held until RST.
  - Push and pop on the same edge when full: both occur, Fill_Level stays FIFO_DEPTH, no overflow.
- Empty boundary: push and pop on the same edge when empty is impossible (pop requires Word_Valid=1). A push into an empty FIFO becomes visible next cycle.
- Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH; Fill_Level is derived from a separate count, never from pointer difference alone.
- Reset mid-operation: an async RST during word accumulation or with a non-empty FIFO clears everything immediately. The first valid bit after release starts a fresh word.

Optional Feature:
- Macro: LFSR_PACKER_PARITY_EN.
- Defined:
  - Adds output port Parity_Out (1 bit) = XOR of all bits of Word_Out.
  - Parity is computed at push time and stored as an extra FIFO bit alongside each word.
  - Parity_Out is 0 when empty or in reset.
- Undefined: port and the extra storage bit are absent; all other behaviour is identical.

Decomposition:
- Shared package lfsr_pkg holds:
  - clog2 constant function.
  - Default word width (8) and FIFO depth (4) constants, shared with the LFSR seed width definitions.
- One natural sub-module: lfsr_sync_fifo (parameterised width/depth, push/pop/full/empty/count). The packer instantiates it with width WORD_W, or WORD_W+1 when parity is enabled.

Test Plan:
- Basic pack: MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive valid cycles, Word_Ready=1 -> Word_Out=8'hB2, Word_Valid high exactly 1 cycle after 8th bit, Fill_Level 1 then 0.
- Gapped input: same bits with Serial_Valid deasserted for 3 cycles between bits 4 and 5 -> Word_Out=8'hB2, no early Word_Valid. Repeat with MSB_FIRST=0 -> Word_Out=8'h4D.
- Overflow: FIFO_DEPTH=4, Word_Ready=0, five words 8'h01..8'h05 -> Fill_Level=4, Overflow=1, head=8'h01. Then drain with Word_Ready=1 -> 01,02,03,04; 05 never appears; Overflow stays 1.
- Full push+pop: FIFO full (01..04), Word_Ready=1 on the same edge as word 8'h05 completes -> Overflow=0, Fill_Level=4, drain order 02,03,04,05.
- Reset mid-word: 3 bits 1,1,1, assert RST for half a cycle, then 8 bits all 0 -> Word_Out=8'h00, Fill_Level=1, Overflow=0. Also drive from a live LFSR (4-bit, seed 4'b1001): 8 packed words match the LFSR bit sequence.
- Parity (LFSR_PACKER_PARITY_EN defined): words 8'hB2 and 8'h07 -> Parity_Out=0 then 1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR block family (seed width, packer word width, FIFO depth).
package lfsr_pkg;

    localparam int DEFAULT_WORD_W     = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int LFSR_SEED_W        = DEFAULT_WORD_W;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty and an occupancy count kept separately from the pointers.
module lfsr_sync_fifo
    import lfsr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_W,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lfsr_bit_packer.sv
// Packs the qualified LFSR serial stream into WORD_W-bit words behind a valid/ready FIFO.
// Optional macro LFSR_PACKER_PARITY_EN adds Parity_Out, stored per entry at push time.
module lfsr_bit_packer
    import lfsr_pkg::*;
#(
    parameter int WORD_W     = DEFAULT_WORD_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Serial_In,
    input  logic                       Serial_Valid,
    output logic [WORD_W-1:0]          Word_Out,
    output logic                       Word_Valid,
    input  logic                       Word_Ready,
    output logic [clog2(FIFO_DEPTH):0] Fill_Level,
    output logic                       Overflow
`ifdef LFSR_PACKER_PARITY_EN
    ,
    output logic                       Parity_Out
`endif
);

    localparam int CNT_W = clog2(WORD_W);
`ifdef LFSR_PACKER_PARITY_EN
    localparam int ENTRY_W = WORD_W + 1;
`else
    localparam int ENTRY_W = WORD_W;
`endif

    logic [WORD_W-1:0]  acc;
    logic [WORD_W-1:0]  acc_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic               word_done;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    always_comb begin
        acc_next = acc;
        if (MSB_FIRST) acc_next = {acc[WORD_W-2:0], Serial_In};
        else           acc_next = {Serial_In, acc[WORD_W-1:1]};
    end

    assign word_done = Serial_Valid && (bit_cnt == CNT_W'(WORD_W - 1));
    assign pop       = Word_Ready & ~fifo_empty;

`ifdef LFSR_PACKER_PARITY_EN
    assign push_entry = {^acc_next, acc_next};
    assign Parity_Out = head_entry[WORD_W];
`else
    assign push_entry = acc_next;
`endif

    assign Word_Out   = head_entry[WORD_W-1:0];
    assign Word_Valid = ~fifo_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc      <= '0;
            bit_cnt  <= '0;
            Overflow <= 1'b0;
        end else begin
            if (Serial_Valid) begin
                acc     <= acc_next;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done && fifo_full && !pop) Overflow <= 1'b1;
        end
    end

    lfsr_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (word_done),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (Fill_Level)
    );

endmodule

// File: tb/tb_lfsr_bit_packer.sv
// Bench for lfsr_bit_packer: MSB-first and LSB-first instances share stimulus; a queue scoreboard tracks both.
module tb_lfsr_bit_packer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       serial_valid;
    logic       word_ready;
    logic [7:0] word_out_m, word_out_l;
    logic       word_valid_m, word_valid_l;
    logic [2:0] fill_m, fill_l;
    logic       ovf_m, ovf_l;
`ifdef LFSR_PACKER_PARITY_EN
    logic       parity_m, parity_l;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic [7:0] acc_m, acc_l;
    int         m_cnt;
    logic       m_ovf;

    lfsr_bit_packer #(.WORD_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
        .CLK(clk), .RST(rst), .Serial_In(serial_in), .Serial_Valid(serial_valid),
        .Word_Out(word_out_m), .Word_Valid(word_valid_m), .Word_Ready(word_ready),
        .Fill_Level(fill_m), .Overflow(ovf_m)
`ifdef LFSR_PACKER_PARITY_EN
        , .Parity_Out(parity_m)
`endif
    );

    lfsr_bit_packer #(.WORD_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .CLK(clk), .RST(rst), .Serial_In(serial_in), .Serial_Valid(serial_valid),
        .Word_Out(word_out_l), .Word_Valid(word_valid_l), .Word_Ready(word_ready),
        .Fill_Level(fill_l), .Overflow(ovf_l)
`ifdef LFSR_PACKER_PARITY_EN
        , .Parity_Out(parity_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare current outputs with the model, then advance the model by the upcoming edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_m", word_valid_m, q_m.size() != 0);
            check("valid_l", word_valid_l, q_l.size() != 0);
            check("fill_m", fill_m, q_m.size());
            check("fill_l", fill_l, q_l.size());
            check("ovf_m", ovf_m, m_ovf);
            check("ovf_l", ovf_l, m_ovf);
            check("word_m", word_out_m, q_m.size() != 0 ? q_m[0] : 8'h00);
            check("word_l", word_out_l, q_l.size() != 0 ? q_l[0] : 8'h00);
`ifdef LFSR_PACKER_PARITY_EN
            check("parity_m", parity_m, q_m.size() != 0 ? ^q_m[0] : 1'b0);
            check("parity_l", parity_l, q_l.size() != 0 ? ^q_l[0] : 1'b0);
`endif
            if (word_ready && q_m.size() != 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                n_pops++;
            end
            if (serial_valid) begin
                acc_m = {acc_m[6:0], serial_in};
                acc_l = {serial_in, acc_l[7:1]};
                if (m_cnt == 7) begin
                    m_cnt = 0;
                    if (q_m.size() < DEPTH) begin
                        q_m.push_back(acc_m);
                        q_l.push_back(acc_l);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q_m.delete();
        q_l.delete();
        acc_m = '0;
        acc_l = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        serial_valid = 1'b0;
        word_ready   = 1'b0;
        rst = 1'b1;
        clear_model();
        #3;
        check("rst_valid", word_valid_m, 1'b0);
        check("rst_fill", fill_m, 3'd0);
        check("rst_ovf", ovf_m, 1'b0);
        check("rst_word", word_out_m, 8'h00);
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic drive_bit(input logic b);
        serial_valid = 1'b1;
        serial_in    = b;
        step();
        serial_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic ready_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && ready_last) word_ready = 1'b1;
            drive_bit(w[i]);
        end
    endtask

    task automatic drain();
        word_ready = 1'b1;
        for (int i = 0; i < 16 && word_valid_m; i++) step();
        check("drain_empty", word_valid_m, 1'b0);
        word_ready = 1'b0;
    endtask

    initial begin
        int         start;
        logic [7:0] pat;
        logic [3:0] lf;
        logic       b;

        rst = 1'b1;
        serial_in = 1'b0;
        serial_valid = 1'b0;
        word_ready = 1'b0;
        clear_model();
        #1;
        check("init_valid", word_valid_m, 1'b0);
        check("init_fill", fill_m, 3'd0);
        check("init_word", word_out_m, 8'h00);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic pack, consumer always ready
        pat = 8'hB2;
        word_ready = 1'b1;
        for (int i = 7; i >= 1; i--) drive_bit(pat[i]);
        check("basic_no_early", word_valid_m, 1'b0);
        drive_bit(pat[0]);
        check("basic_valid", word_valid_m, 1'b1);
        check("basic_word_m", word_out_m, 8'hB2);
        check("basic_word_l", word_out_l, 8'h4D);
        check("basic_fill1", fill_m, 3'd1);
        step();
        check("basic_fill0", fill_m, 3'd0);

        // Gapped input
        word_ready = 1'b0;
        for (int i = 7; i >= 4; i--) drive_bit(pat[i]);
        for (int g = 0; g < 3; g++) begin
            step();
            check("gap_no_valid", word_valid_m, 1'b0);
        end
        for (int i = 3; i >= 1; i--) drive_bit(pat[i]);
        check("gap_no_early", word_valid_m, 1'b0);
        drive_bit(pat[0]);
        check("gap_word_m", word_out_m, 8'hB2);
        check("gap_word_l", word_out_l, 8'h4D);
        drain();

        // Overflow with consumer stalled
        do_reset();
        start = n_pops;
        for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0);
        check("ovf_fill", fill_m, 3'd4);
        check("ovf_flag", ovf_m, 1'b1);
        check("ovf_head", word_out_m, 8'h01);
        drain();
        check("ovf_drained", n_pops - start, 4);
        check("ovf_sticky", ovf_m, 1'b1);

        // Push and pop on the same edge while full
        do_reset();
        start = n_pops;
        for (int w = 1; w <= 4; w++) send_word(8'(w), 1'b0);
        send_word(8'h05, 1'b1);
        check("fpp_fill", fill_m, 3'd4);
        check("fpp_ovf", ovf_m, 1'b0);
        check("fpp_head", word_out_m, 8'h02);
        drain();
        check("fpp_drained", n_pops - start, 5);

        // Reset in the middle of a word
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) drive_bit(1'b0);
        check("rmw_word", word_out_m, 8'h00);
        check("rmw_valid", word_valid_m, 1'b1);
        check("rmw_fill", fill_m, 3'd1);
        check("rmw_ovf", ovf_m, 1'b0);
        drain();

        // Live 4-bit LFSR source with gaps and a stuttering consumer
        start = n_pops;
        lf = 4'b1001;
        for (int i = 0; i < 64; i++) begin
            word_ready = (i % 5) != 3;
            if ($urandom_range(0, 3) == 0) step();
            b = lf[3];
            lf = {lf[2:0], lf[3] ^ lf[2]};
            drive_bit(b);
        end
        drain();
        check("lfsr_words", n_pops - start, 8);

`ifdef LFSR_PACKER_PARITY_EN
        do_reset();
        send_word(8'hB2, 1'b0);
        send_word(8'h07, 1'b0);
        check("par_b2", parity_m, 1'b0);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        check("par_07_word", word_out_m, 8'h07);
        check("par_07", parity_m, 1'b1);
        drain();
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
